// File: rtl/rs232_to_axis.sv
// rs232_to_axis
//   Receives 8N1 RS232 frames on rxd and presents each byte on an AXI-stream
//   style master port. A small FIFO absorbs the extra byte that a far-end
//   transmitter may still send after rtsn has been raised.
//
// Ports
//   clock      in   system clock
//   resetn     in   asynchronous active-low reset
//   rxd        in   serial input from far-end TXD (asynchronous, idle high)
//   rtsn       out  flow control to far-end CTSn, high = stop sending
//   odata      out  received byte at the FIFO head
//   ovalid     out  FIFO not empty
//   oready     in   downstream accepts odata when ovalid && oready
//   frame_err  out  one-cycle pulse, stop bit sampled low, byte dropped
//   overrun    out  one-cycle pulse, good byte arrived with FIFO full, dropped
module rs232_to_axis #(
   parameter int CLOCK_FREQ = 133000000,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       rxd,
   output logic       rtsn,
   output logic [7:0] odata,
   output logic       ovalid,
   input  logic       oready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int BAUD_COUNT = CLOCK_FREQ / BAUD_RATE;
   localparam int TW         = $clog2(BAUD_COUNT);
   localparam int AW         = $clog2(FIFO_DEPTH);
   localparam int CW         = AW + 1;

   localparam logic [TW-1:0] HALF_RELOAD = TW'(BAUD_COUNT / 2 - 1);
   localparam logic [TW-1:0] FULL_RELOAD = TW'(BAUD_COUNT - 1);
   localparam logic [CW-1:0] RTS_LEVEL   = CW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0] FULL_LEVEL  = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   logic          rxMeta_q;
   logic          rxs_q;
   state_t        state_q;
   logic [TW-1:0] timer_q;
   logic [2:0]    bitIdx_q;
   logic [7:0]    shift_q;
   logic          frameErr_q;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wrPtr_q;
   logic [AW-1:0] rdPtr_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic          rtsn_q;
   logic          overrun_q;

   logic          tick;
   logic          push;
   logic          pop;
   logic          full;
   logic          pushAccept;

   // Two-flop synchronizer; both flops reset to the idle line level so a
   // reset never looks like a start bit.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rxMeta_q <= 1'b1;
         rxs_q    <= 1'b1;
      end else begin
         rxMeta_q <= rxd;
         rxs_q    <= rxMeta_q;
      end
   end

   // Tick is the underflow of the bit timer; a good stop bit pushes the byte.
   // A push into a full FIFO is only accepted when a pop frees the head slot
   // in the same cycle.
   always_comb begin
      tick       = (timer_q == '0);
      push       = (state_q == STOP) && tick && rxs_q;
      pop        = ovalid && oready;
      full       = (count_q == FULL_LEVEL);
      pushAccept = push && (!full || pop);
      count_d    = count_q;
      case ({pushAccept, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Receive FSM. The first reload of half a bit puts every later tick in the
   // middle of a bit cell. A low stop bit parks the FSM in BREAK so a line
   // held low cannot be mistaken for a stream of zero bytes.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         bitIdx_q   <= '0;
         shift_q    <= '0;
         frameErr_q <= 1'b0;
      end else begin
         frameErr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!rxs_q) begin
                  state_q <= START;
                  timer_q <= HALF_RELOAD;
               end
            end
            START: begin
               if (tick) begin
                  if (rxs_q) begin
                     state_q <= IDLE;
                  end else begin
                     state_q  <= DATA;
                     bitIdx_q <= '0;
                     timer_q  <= FULL_RELOAD;
                  end
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end
            DATA: begin
               if (tick) begin
                  shift_q <= {rxs_q, shift_q[7:1]};
                  timer_q <= FULL_RELOAD;
                  if (bitIdx_q == 3'd7) begin
                     state_q <= STOP;
                  end else begin
                     bitIdx_q <= bitIdx_q + 1'b1;
                  end
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end
            STOP: begin
               if (tick) begin
                  if (rxs_q) begin
                     state_q <= IDLE;
                  end else begin
                     frameErr_q <= 1'b1;
                     state_q    <= BREAK;
                  end
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end
            BREAK: begin
               if (rxs_q) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Receive FIFO. rtsn is computed from the post-update count so the far
   // end is told to stop while one slot is still free for a byte already on
   // the wire. Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         count_q   <= '0;
         rtsn_q    <= 1'b1;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= push && full && !pop;
         if (pushAccept) begin
            mem_q[wrPtr_q] <= shift_q;
            wrPtr_q        <= wrPtr_q + 1'b1;
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         count_q <= count_d;
         rtsn_q  <= (count_d >= RTS_LEVEL);
      end
   end

   assign odata     = mem_q[rdPtr_q];
   assign ovalid    = (count_q != '0);
   assign rtsn      = rtsn_q;
   assign frame_err = frameErr_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_rs232_to_axis.sv
// Testbench for rs232_to_axis: directed scenarios plus randomized traffic,
// compared against a queue-based model of the bytes the far end sent.
module tb_rs232_to_axis;

   localparam int CLOCK_FREQ = 1600;
   localparam int BAUD_RATE  = 100;
   localparam int FIFO_DEPTH = 4;
   localparam int BIT_CLOCKS = CLOCK_FREQ / BAUD_RATE;

   logic       clock  = 1'b0;
   logic       resetn = 1'b0;
   logic       rxd    = 1'b1;
   logic       oready = 1'b1;
   logic       rtsn;
   logic [7:0] odata;
   logic       ovalid;
   logic       frame_err;
   logic       overrun;

   int compareCount  = 0;
   int mismatchCount = 0;

   logic [7:0] gotQ[$];
   logic [7:0] expQ[$];
   int validCycles         = 0;
   int frameErrPulses      = 0;
   int overrunPulses       = 0;
   int pulseViolations     = 0;
   int stabilityViolations = 0;

   logic       prevHold     = 1'b0;
   logic [7:0] prevData     = 8'h00;
   logic       prevFrameErr = 1'b0;
   logic       prevOverrun  = 1'b0;

   rs232_to_axis #(
      .CLOCK_FREQ(CLOCK_FREQ),
      .BAUD_RATE (BAUD_RATE),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clock    (clock),
      .resetn   (resetn),
      .rxd      (rxd),
      .rtsn     (rtsn),
      .odata    (odata),
      .ovalid   (ovalid),
      .oready   (oready),
      .frame_err(frame_err),
      .overrun  (overrun)
   );

   always #5 clock = ~clock;

   // Output monitor on the falling edge: collects accepted beats, counts
   // status pulses and watches the AXI hold rule and pulse widths.
   always @(negedge clock) begin
      if (resetn) begin
         if (prevHold && (!ovalid || odata !== prevData)) stabilityViolations++;
         if (ovalid) validCycles++;
         if (ovalid && oready) gotQ.push_back(odata);
         if (frame_err) frameErrPulses++;
         if (overrun) overrunPulses++;
         if ((frame_err && prevFrameErr) || (overrun && prevOverrun) || (frame_err && overrun))
            pulseViolations++;
      end
      prevHold     = resetn && ovalid && !oready;
      prevData     = odata;
      prevFrameErr = resetn && frame_err;
      prevOverrun  = resetn && overrun;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compareCount++;
      assert (obs === exp) else begin
         mismatchCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compares everything received since startIdx with the model queue.
   task automatic checkBytes(input string tag, input int startIdx);
      checkOutput({tag, "_count"}, 32'(gotQ.size() - startIdx), 32'(expQ.size()));
      foreach (expQ[i]) begin
         if (startIdx + i < gotQ.size())
            checkOutput($sformatf("%s_byte%0d", tag, i), 32'(gotQ[startIdx + i]), 32'(expQ[i]));
      end
      expQ.delete();
   endtask

   // Sends one 8N1 frame, each cell BIT_CLOCKS clocks long, LSB first.
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
      logic [9:0] cells;
      cells = {stopBit, data, 1'b0};
      for (int b = 0; b < 10; b++) begin
         @(posedge clock);
         #1 rxd = cells[b];
         repeat (BIT_CLOCKS - 1) @(posedge clock);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
   endtask

   task automatic setReady(input logic r);
      @(posedge clock);
      #1 oready = r;
   endtask

   initial begin
      int         snapIdx;
      int         snapErr;
      int         snapOvr;
      int         snapValid;
      logic [7:0] b;
      logic [7:0] held[4];

      $display("[TB] start");

      // Reset values
      idle(3);
      @(negedge clock);
      checkOutput("reset_rtsn", 32'(rtsn), 32'd1);
      checkOutput("reset_ovalid", 32'(ovalid), 32'd0);
      checkOutput("reset_odata", 32'(odata), 32'd0);
      checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
      checkOutput("reset_overrun", 32'(overrun), 32'd0);
      @(posedge clock);
      #1 resetn = 1'b1;
      @(posedge clock);
      @(negedge clock);
      checkOutput("rtsn_after_reset", 32'(rtsn), 32'd0);

      // Single byte with a ready sink
      snapIdx = gotQ.size(); snapErr = frameErrPulses; snapOvr = overrunPulses;
      snapValid = validCycles;
      applyStimulus(8'hA5, 1'b1);
      idle(20);
      expQ.push_back(8'hA5);
      checkBytes("t1", snapIdx);
      checkOutput("t1_valid_cycles", 32'(validCycles - snapValid), 32'd1);
      checkOutput("t1_frame_err", 32'(frameErrPulses - snapErr), 32'd0);
      checkOutput("t1_overrun", 32'(overrunPulses - snapOvr), 32'd0);

      // Short glitch is rejected
      snapIdx = gotQ.size(); snapErr = frameErrPulses; snapOvr = overrunPulses;
      @(posedge clock);
      #1 rxd = 1'b0;
      idle(5);
      #1 rxd = 1'b1;
      idle(40);
      checkBytes("t2", snapIdx);
      checkOutput("t2_frame_err", 32'(frameErrPulses - snapErr), 32'd0);
      checkOutput("t2_overrun", 32'(overrunPulses - snapOvr), 32'd0);

      // Framing error, held break, then a good byte
      snapIdx = gotQ.size(); snapErr = frameErrPulses;
      applyStimulus(8'h3C, 1'b0);
      idle(40);
      #1 rxd = 1'b1;
      idle(20);
      applyStimulus(8'h81, 1'b1);
      idle(20);
      expQ.push_back(8'h81);
      checkBytes("t3", snapIdx);
      checkOutput("t3_frame_err", 32'(frameErrPulses - snapErr), 32'd1);

      // Fill with the sink stalled: rtsn at three entries, fifth byte overruns
      snapIdx = gotQ.size(); snapOvr = overrunPulses;
      setReady(1'b0);
      applyStimulus(8'h01, 1'b1);
      applyStimulus(8'h02, 1'b1);
      @(negedge clock);
      checkOutput("t4_rtsn_two", 32'(rtsn), 32'd0);
      applyStimulus(8'h03, 1'b1);
      @(negedge clock);
      checkOutput("t4_rtsn_three", 32'(rtsn), 32'd1);
      checkOutput("t4_odata_head", 32'(odata), 32'h01);
      applyStimulus(8'h04, 1'b1);
      applyStimulus(8'h05, 1'b1);
      idle(10);
      checkOutput("t4_overrun", 32'(overrunPulses - snapOvr), 32'd1);
      checkOutput("t4_rtsn_full", 32'(rtsn), 32'd1);
      @(posedge clock);
      #1 oready = 1'b1;
      @(negedge clock);
      @(negedge clock);
      checkOutput("t4_rtsn_count3", 32'(rtsn), 32'd1);
      @(negedge clock);
      checkOutput("t4_rtsn_count2", 32'(rtsn), 32'd0);
      idle(10);
      expQ = '{8'h01, 8'h02, 8'h03, 8'h04};
      checkBytes("t4", snapIdx);

      // Full FIFO, pop in the very cycle of the stop-bit push
      setReady(1'b0);
      for (int i = 0; i < 4; i++) begin
         held[i] = 8'($urandom);
         applyStimulus(held[i], 1'b1);
      end
      b = 8'($urandom);
      snapIdx = gotQ.size(); snapOvr = overrunPulses;
      fork
         applyStimulus(b, 1'b1);
         begin
            @(posedge clock);
            repeat (BIT_CLOCKS * 19 / 2 + 2) @(posedge clock);
            #1 oready = 1'b1;
            @(posedge clock);
            #1 oready = 1'b0;
         end
      join
      idle(5);
      checkOutput("t5_overrun", 32'(overrunPulses - snapOvr), 32'd0);
      checkOutput("t5_rtsn", 32'(rtsn), 32'd1);
      setReady(1'b1);
      idle(10);
      expQ = '{held[0], held[1], held[2], held[3], b};
      checkBytes("t5", snapIdx);

      // Reset in the middle of a frame discards it and empties the FIFO
      setReady(1'b0);
      applyStimulus(8'($urandom), 1'b1);
      idle(5);
      snapIdx = gotQ.size();
      fork
         applyStimulus(8'h55, 1'b1);
         begin
            @(posedge clock);
            repeat (BIT_CLOCKS * 5 + 8) @(posedge clock);
            #1 resetn = 1'b0;
            @(negedge clock);
            checkOutput("t6_rtsn", 32'(rtsn), 32'd1);
            checkOutput("t6_ovalid", 32'(ovalid), 32'd0);
            checkOutput("t6_odata", 32'(odata), 32'd0);
         end
      join
      idle(5);
      #1 resetn = 1'b1;
      oready = 1'b1;
      idle(10);
      applyStimulus(8'h66, 1'b1);
      idle(20);
      expQ.push_back(8'h66);
      checkBytes("t6", snapIdx);

      // Randomized traffic with a randomly stalling sink
      snapIdx = gotQ.size(); snapErr = frameErrPulses; snapOvr = overrunPulses;
      fork
         for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            expQ.push_back(b);
            applyStimulus(b, 1'b1);
         end
         begin
            repeat (6 * 10 * BIT_CLOCKS) begin
               @(posedge clock);
               #1 oready = 1'($urandom_range(0, 1));
            end
         end
      join
      setReady(1'b1);
      idle(20);
      checkBytes("rand", snapIdx);
      checkOutput("rand_frame_err", 32'(frameErrPulses - snapErr), 32'd0);
      checkOutput("rand_overrun", 32'(overrunPulses - snapOvr), 32'd0);

      checkOutput("pulse_width", 32'(pulseViolations), 32'd0);
      checkOutput("axi_hold", 32'(stabilityViolations), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
